// File: rtl/aes_pkg.sv
// Shared AES decryption helpers: block width, byte indexing, and the
// InvShiftRows / key-row / round-constant transforms used by the pipeline.
package aes_pkg;

   localparam int         AES_BLOCK_W   = 128;
   localparam logic [7:0] RCON_WRAP_IN  = 8'h1B;
   localparam logic [7:0] RCON_WRAP_OUT = 8'h80;

   // Byte n of a block sits at bits [8n+7:8n].
   function automatic int byte_lsb(input int n);
      return 8 * n;
   endfunction

   // Row r of the output takes column (c - r) mod 4 of the same input row.
   function automatic logic [AES_BLOCK_W-1:0] inv_shift_rows(input logic [AES_BLOCK_W-1:0] s);
      logic [AES_BLOCK_W-1:0] r;
      r = {AES_BLOCK_W{1'b0}};
      for (int row = 0; row < 4; row++) begin
         for (int col = 0; col < 4; col++) begin
            r[byte_lsb(4 * row + col) +: 8] = s[byte_lsb(4 * row + ((col + 4 - row) % 4)) +: 8];
         end
      end
      return r;
   endfunction

   function automatic logic [AES_BLOCK_W-1:0] key_rot_row3_right(input logic [AES_BLOCK_W-1:0] k);
      logic [AES_BLOCK_W-1:0] r;
      r = k;
      r[AES_BLOCK_W-1 -: 32] = {k[AES_BLOCK_W-9 -: 24], k[AES_BLOCK_W-1 -: 8]};
      return r;
   endfunction

   // Steps backwards through the rcon sequence; 8'h01 falls off to 8'h00.
   function automatic logic [7:0] rcon_prev(input logic [7:0] rc);
      logic [7:0] r;
      if (rc == RCON_WRAP_IN) begin
         r = RCON_WRAP_OUT;
      end else begin
         r = {1'b0, rc[7:1]};
      end
      return r;
   endfunction

endpackage

// File: rtl/aes_pipe_reg.sv
// One pipeline slot: payload register plus valid bit, loaded when enabled,
// with a configurable synchronous reset value.
module aes_pipe_reg #(
   parameter int           W       = 8,
   parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic         next_valid,
   input  logic [W-1:0] next_data,
   output logic         valid,
   output logic [W-1:0] data
);

   // Slot state: cleared by reset, otherwise reloaded whenever the slot advances.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= RST_VAL;
      end else if (load) begin
         valid <= next_valid;
         data  <= next_data;
      end
   end

endmodule

// File: rtl/inv_shift_row_stage.sv
// Decryption pipeline stage: InvShiftRows, key row-3 rotate, rcon step-back,
// carried through a two-slot valid/ready register pipeline.
module inv_shift_row_stage
   import aes_pkg::*;
#(
   parameter int DATA_W     = 128,
   parameter int PIPE_DEPTH = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] state_in,
   input  logic [DATA_W-1:0] key_in,
   input  logic [7:0]        rcon_in,
   input  logic              empty_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] state_out,
   output logic [DATA_W-1:0] key_out,
   output logic [7:0]        rcon_out,
   output logic              empty
);

   localparam int             PAY_W   = 2 * DATA_W + 8 + 1;
   // Idle slots read as an all-zero bubble with the empty marker set.
   localparam logic [PAY_W-1:0] PAY_RST = {{(PAY_W - 1){1'b0}}, 1'b1};

   logic [PAY_W-1:0]      s1_in_s;
   logic [PAY_W-1:0]      s1_data_r;
   logic [PAY_W-1:0]      s2_data_r;
   logic                  s1_v_r;
   logic                  s2_v_r;
   logic [PIPE_DEPTH-1:0] stage_v_s;
   logic                  adv1_s;
   logic                  adv2_s;

   assign s1_in_s = {inv_shift_rows(state_in), key_rot_row3_right(key_in),
                     rcon_prev(rcon_in), empty_in};

   assign stage_v_s = {s2_v_r, s1_v_r};
   assign adv2_s    = !stage_v_s[PIPE_DEPTH-1] || out_ready;
   assign adv1_s    = !stage_v_s[0] || adv2_s;
   assign in_ready  = adv1_s;

   aes_pipe_reg #(.W(PAY_W), .RST_VAL(PAY_RST)) u_stage1 (
      .clock      (clock),
      .reset      (reset),
      .load       (adv1_s),
      .next_valid (in_valid),
      .next_data  (s1_in_s),
      .valid      (s1_v_r),
      .data       (s1_data_r)
   );

   aes_pipe_reg #(.W(PAY_W), .RST_VAL(PAY_RST)) u_stage2 (
      .clock      (clock),
      .reset      (reset),
      .load       (adv2_s),
      .next_valid (s1_v_r),
      .next_data  (s1_data_r),
      .valid      (s2_v_r),
      .data       (s2_data_r)
   );

   assign out_valid = s2_v_r;
   assign {state_out, key_out, rcon_out, empty} = s2_data_r;

endmodule

// File: tb/tb_inv_shift_row_stage.sv
// Self-checking bench for inv_shift_row_stage: directed vectors, backpressure,
// full-rate, mid-stream reset and a randomized scoreboard run.
module tb_inv_shift_row_stage;

   logic         clock = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] state_in;
   logic [127:0] key_in;
   logic [7:0]   rcon_in;
   logic         empty_in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] state_out;
   logic [127:0] key_out;
   logic [7:0]   rcon_out;
   logic         empty;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [127:0] st;
      logic [127:0] ky;
      logic [7:0]   rc;
      logic         em;
   } beat_t;

   typedef struct {
      beat_t in_b;
      beat_t exp_b;
   } vec_t;

   logic [7:0] rc_seq [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                               8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
   beat_t sb_q [$];

   inv_shift_row_stage dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .state_in  (state_in),
      .key_in    (key_in),
      .rcon_in   (rcon_in),
      .empty_in  (empty_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .state_out (state_out),
      .key_out   (key_out),
      .rcon_out  (rcon_out),
      .empty     (empty)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [264:0] act, input logic [264:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic beat_t out_beat();
      beat_t b;
      b = {state_out, key_out, rcon_out, empty};
      return b;
   endfunction

   // Reference: row r is rotated right r times; key row 3 rotated right once;
   // rcon is the previous entry of the AES round-constant sequence.
   function automatic beat_t model(input beat_t b);
      logic [7:0] g [16];
      logic [7:0] t;
      beat_t r;
      for (int n = 0; n < 16; n++) g[n] = b.st[8*n +: 8];
      for (int row = 1; row < 4; row++) begin
         for (int k = 0; k < row; k++) begin
            t = g[4*row+3];
            g[4*row+3] = g[4*row+2];
            g[4*row+2] = g[4*row+1];
            g[4*row+1] = g[4*row];
            g[4*row]   = t;
         end
      end
      for (int n = 0; n < 16; n++) r.st[8*n +: 8] = g[n];
      r.ky = b.ky;
      r.ky[127:96] = {b.ky[119:96], b.ky[127:120]};
      r.rc = 8'hEE;
      for (int i = 0; i < 10; i++) begin
         if (rc_seq[i] == b.rc) r.rc = (i == 0) ? 8'h00 : rc_seq[i-1];
      end
      r.em = b.em;
      return r;
   endfunction

   function automatic beat_t rand_beat();
      beat_t b;
      b.st = {$urandom, $urandom, $urandom, $urandom};
      b.ky = {$urandom, $urandom, $urandom, $urandom};
      b.rc = rc_seq[$urandom_range(0, 9)];
      b.em = 1'($urandom_range(0, 1));
      return b;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic iv, input beat_t b);
      in_valid = iv;
      state_in = b.st;
      key_in   = b.ky;
      rcon_in  = b.rc;
      empty_in = b.em;
   endtask

   // One scoreboarded cycle; reports whether in_ready and a pop were seen.
   task automatic sb_cycle(input logic iv, input logic ordy, output logic ir, output logic popped);
      beat_t b;
      beat_t e;
      b = rand_beat();
      drive(iv, b);
      out_ready = ordy;
      #1;
      ir = in_ready;
      popped = out_valid && out_ready;
      if (popped) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_beat", 265'd1, 265'd0);
         end else begin
            e = sb_q.pop_front();
            chk("sb_beat", out_beat(), e);
         end
      end
      if (in_valid && in_ready) sb_q.push_back(model(b));
      @(posedge clock);
      #1;
   endtask

   initial begin
      vec_t  vecs [4];
      beat_t zb;
      beat_t hold_b;
      beat_t rb;
      logic  ir;
      logic  pp;
      logic [7:0] tag;
      int    got;
      int    gaps;
      int    pops;
      int    first_pop;
      int    last_pop;
      logic  ir_all;

      zb = '0;
      reset = 1'b1;
      out_ready = 1'b0;
      drive(1'b0, zb);
      step();
      step();
      reset = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_payload", out_beat(), {128'h0, 128'h0, 8'h00, 1'b1});
      chk("rst_in_ready", in_ready, 1'b1);

      // Directed vectors: the known-answer pattern plus the rcon boundaries.
      vecs[0].in_b  = {128'h0F0E0D0C_0B0A0908_07060504_03020100,
                       128'h1F1E1D1C_1B1A1918_17161514_13121110, 8'h36, 1'b0};
      vecs[0].exp_b = {128'h0C0F0E0D_09080B0A_06050407_03020100,
                       128'h1E1D1C1F_1B1A1918_17161514_13121110, 8'h1B, 1'b0};
      for (int i = 1; i < 4; i++) begin
         vecs[i].in_b = rand_beat();
         vecs[i].in_b.rc = (i == 1) ? 8'h1B : (i == 2) ? 8'h80 : 8'h01;
         vecs[i].exp_b = model(vecs[i].in_b);
         vecs[i].exp_b.rc = (i == 1) ? 8'h80 : (i == 2) ? 8'h40 : 8'h00;
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, vecs[i].in_b);
         step();
         drive(1'b0, zb);
         #1;
         chk($sformatf("vec%0d_latency", i), out_valid, 1'b0);
         step();
         chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
         chk($sformatf("vec%0d_beat", i), out_beat(), vecs[i].exp_b);
      end
      step();

      // Backpressure: beats 1..5, downstream stalled in cycles 3-6.
      tag = 8'd1;
      got = 0;
      gaps = 0;
      hold_b = '0;
      for (int c = 1; c <= 40 && got < 5; c++) begin
         rb = '0;
         rb.st = {120'h0, tag};
         rb.ky = {120'h0, tag};
         rb.rc = 8'h02;
         drive(tag <= 8'd5, rb);
         out_ready = !(c >= 3 && c <= 6);
         #1;
         if (c == 3) begin
            chk("bp_in_ready_full", in_ready, 1'b0);
            chk("bp_out_valid_stall", out_valid, 1'b1);
            hold_b = out_beat();
         end
         if (c > 3 && c <= 6) chk($sformatf("bp_hold_c%0d", c), out_beat(), hold_b);
         if (c >= 7 && !out_valid) gaps++;
         if (out_valid && out_ready) begin
            got++;
            chk($sformatf("bp_order%0d", got), state_out[7:0], 8'(got));
         end
         if (in_valid && in_ready) tag++;
         step();
      end
      chk("bp_count", got, 5);
      chk("bp_gaps", gaps, 0);
      drive(1'b0, zb);
      out_ready = 1'b1;
      step();
      step();

      // Full-rate streaming.
      sb_q.delete();
      ir_all = 1'b1;
      pops = 0;
      first_pop = -1;
      last_pop = -1;
      for (int c = 0; c < 24; c++) begin
         sb_cycle(c < 20, 1'b1, ir, pp);
         if (c < 20) ir_all = ir_all & ir;
         if (pp) begin
            pops++;
            if (first_pop < 0) first_pop = c;
            last_pop = c;
         end
      end
      chk("fr_in_ready_high", ir_all, 1'b1);
      chk("fr_beats", pops, 20);
      chk("fr_consecutive", last_pop - first_pop, 19);

      // Randomized handshake against the scoreboard.
      for (int c = 0; c < 10000; c++) begin
         sb_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ir, pp);
      end
      for (int c = 0; c < 6; c++) sb_cycle(1'b0, 1'b1, ir, pp);
      chk("rand_drained", sb_q.size(), 0);

      // Reset with two beats in flight.
      out_ready = 1'b0;
      drive(1'b1, rand_beat());
      step();
      drive(1'b1, rand_beat());
      step();
      drive(1'b0, zb);
      chk("mr_two_in_flight", {in_ready, out_valid}, 2'b01);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      chk("mr_out_valid", out_valid, 1'b0);
      chk("mr_payload", out_beat(), {128'h0, 128'h0, 8'h00, 1'b1});
      chk("mr_in_ready", in_ready, 1'b1);
      out_ready = 1'b1;
      rb = rand_beat();
      drive(1'b1, rb);
      step();
      drive(1'b0, zb);
      #1;
      chk("mr_latency", out_valid, 1'b0);
      step();
      chk("mr_first_valid", out_valid, 1'b1);
      chk("mr_first_beat", out_beat(), model(rb));
      step();
      chk("mr_no_dup", out_valid, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
